// File: rtl/synchronous_loadable_up_counter.sv
// synchronous_loadable_up_counter: loadable up-counter to a programmable limit with auto-reload or one-shot stop
module synchronous_loadable_up_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] data,
    input  logic             en,
    input  logic [WIDTH-1:0] limit,
    input  logic             mode,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             carry,
    output logic             done
);
    typedef enum logic {RUN, HALT} state_t;
    state_t state, state_nxt;
    logic [WIDTH-1:0] count_nxt;
    logic tc_nxt, carry_nxt, done_nxt, step, term;
    assign step = !load && state == RUN && en;
    assign term = count == limit;
    // A terminal step never takes the natural wrap, so tc and carry stay exclusive
    always_comb begin
        state_nxt = load ? RUN : (step && term && mode) ? HALT : state;
        count_nxt = load ? data : !step ? count : term ? (mode ? count : '0) : count + 1'b1;
        tc_nxt    = step && term;
        carry_nxt = step && !term && &count;
        done_nxt  = load ? 1'b0 : (step && term && mode) ? 1'b1 : done;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
            count <= '0;
            tc    <= 1'b0;
            carry <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            count <= count_nxt;
            tc    <= tc_nxt;
            carry <= carry_nxt;
            done  <= done_nxt;
        end
    end
endmodule

// File: tb/tb_synchronous_loadable_up_counter.sv
// tb_synchronous_loadable_up_counter: directed scenarios with hand-computed expectations
module tb_synchronous_loadable_up_counter;
    logic clk = 1'b0;
    logic rst_n, load, en, mode;
    logic [3:0] data, limit, count;
    logic tc, carry, done;
    int n_checks = 0;
    int n_fail = 0;

    synchronous_loadable_up_counter #(.WIDTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .load(load), .data(data), .en(en),
        .limit(limit), .mode(mode), .count(count), .tc(tc), .carry(carry), .done(done)
    );

    always #5 clk = ~clk;

    // Inputs change on the falling edge; outputs are checked on the following falling edge
    task automatic cyc(input logic l, input logic [3:0] d, input logic e);
        load = l;
        data = d;
        en = e;
        @(negedge clk);
    endtask

    task automatic test_reset;
        rst_n = 1'b0; load = 0; data = 0; en = 0; limit = 0; mode = 0;
        #12;
        n_checks++;
        if ({count, tc, carry, done} !== 7'b0) begin
            n_fail++;
            $display("FAIL reset: count=%0d tc=%b carry=%b done=%b, required all 0", count, tc, carry, done);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_auto_reload;
        int exp_c[7] = '{1, 2, 3, 4, 5, 0, 1};
        logic exp_t[7] = '{0, 0, 0, 0, 0, 1, 0};
        limit = 5; mode = 0;
        for (int i = 0; i < 7; i++) begin
            cyc(0, 0, 1);
            n_checks++;
            if (count !== 4'(exp_c[i]) || tc !== exp_t[i] || carry !== 1'b0) begin
                n_fail++;
                $display("FAIL auto_reload[%0d]: count=%0d tc=%b carry=%b, required %0d %b 0", i, count, tc, carry, exp_c[i], exp_t[i]);
            end
        end
        cyc(0, 0, 0);
    endtask

    task automatic test_one_shot;
        int exp_c[6] = '{7, 8, 9, 9, 9, 9};
        logic exp_t[6] = '{0, 0, 0, 1, 0, 0};
        logic exp_d[6] = '{0, 0, 0, 1, 1, 1};
        limit = 9; mode = 1;
        cyc(1, 6, 0);
        n_checks++;
        if (count !== 4'd6 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL one_shot_load: count=%0d done=%b, required 6 0", count, done);
        end
        for (int i = 0; i < 6; i++) begin
            cyc(0, 0, 1);
            n_checks++;
            if (count !== 4'(exp_c[i]) || tc !== exp_t[i] || done !== exp_d[i]) begin
                n_fail++;
                $display("FAIL one_shot[%0d]: count=%0d tc=%b done=%b, required %0d %b %b", i, count, tc, done, exp_c[i], exp_t[i], exp_d[i]);
            end
        end
        mode = 0;
        cyc(0, 0, 1);
        n_checks++;
        if (count !== 4'd9 || tc !== 1'b0 || done !== 1'b1) begin
            n_fail++;
            $display("FAIL halt_mode_change: count=%0d tc=%b done=%b, required 9 0 1", count, tc, done);
        end
        mode = 1;
        cyc(1, 2, 1);
        n_checks++;
        if (count !== 4'd2 || done !== 1'b0 || tc !== 1'b0) begin
            n_fail++;
            $display("FAIL one_shot_reload: count=%0d done=%b tc=%b, required 2 0 0", count, done, tc);
        end
        mode = 0;
        cyc(0, 0, 0);
    endtask

    task automatic test_load_vs_enable;
        limit = 5; mode = 0;
        cyc(1, 5, 0);
        cyc(1, 3, 1);
        n_checks++;
        if (count !== 4'd3 || tc !== 1'b0) begin
            n_fail++;
            $display("FAIL load_priority: count=%0d tc=%b, required 3 0", count, tc);
        end
        cyc(0, 0, 1);
        n_checks++;
        if (count !== 4'd4) begin
            n_fail++;
            $display("FAIL load_resume4: count=%0d, required 4", count);
        end
        cyc(0, 0, 1);
        n_checks++;
        if (count !== 4'd5 || tc !== 1'b0) begin
            n_fail++;
            $display("FAIL load_resume5: count=%0d tc=%b, required 5 0", count, tc);
        end
        cyc(0, 0, 0);
    endtask

    task automatic test_wrap;
        int exp_c[8] = '{15, 0, 1, 2, 3, 4, 5, 0};
        logic exp_k[8] = '{0, 1, 0, 0, 0, 0, 0, 0};
        logic exp_t[8] = '{0, 0, 0, 0, 0, 0, 0, 1};
        limit = 5; mode = 0;
        cyc(1, 14, 0);
        for (int i = 0; i < 8; i++) begin
            cyc(0, 0, 1);
            n_checks++;
            if (count !== 4'(exp_c[i]) || carry !== exp_k[i] || tc !== exp_t[i]) begin
                n_fail++;
                $display("FAIL wrap[%0d]: count=%0d carry=%b tc=%b, required %0d %b %b", i, count, carry, tc, exp_c[i], exp_k[i], exp_t[i]);
            end
        end
        cyc(0, 0, 0);
        n_checks++;
        if (count !== 4'd0 || tc !== 1'b0 || carry !== 1'b0) begin
            n_fail++;
            $display("FAIL wrap_hold: count=%0d tc=%b carry=%b, required 0 0 0", count, tc, carry);
        end
    endtask

    task automatic test_degenerate;
        limit = 0; mode = 0;
        cyc(1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 1);
            n_checks++;
            if (count !== 4'd0 || tc !== 1'b1 || carry !== 1'b0) begin
                n_fail++;
                $display("FAIL limit0[%0d]: count=%0d tc=%b carry=%b, required 0 1 0", i, count, tc, carry);
            end
        end
        limit = 15;
        cyc(1, 14, 0);
        cyc(0, 0, 1);
        n_checks++;
        if (count !== 4'd15 || tc !== 1'b0 || carry !== 1'b0) begin
            n_fail++;
            $display("FAIL limit15_step: count=%0d tc=%b carry=%b, required 15 0 0", count, tc, carry);
        end
        cyc(0, 0, 1);
        n_checks++;
        if (count !== 4'd0 || tc !== 1'b1 || carry !== 1'b0) begin
            n_fail++;
            $display("FAIL limit15_term: count=%0d tc=%b carry=%b, required 0 1 0", count, tc, carry);
        end
        cyc(0, 0, 0);
    endtask

    task automatic test_async_reset;
        limit = 9; mode = 0;
        cyc(1, 6, 0);
        cyc(0, 0, 1);
        n_checks++;
        if (count !== 4'd7) begin
            n_fail++;
            $display("FAIL async_pre: count=%0d, required 7", count);
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({count, tc, carry, done} !== 7'b0) begin
            n_fail++;
            $display("FAIL async_reset_count: count=%0d tc=%b carry=%b done=%b, required all 0", count, tc, carry, done);
        end
        @(negedge clk);
        rst_n = 1'b1;
        mode = 1; limit = 1;
        cyc(0, 0, 1);
        cyc(0, 0, 1);
        n_checks++;
        if (done !== 1'b1 || count !== 4'd1) begin
            n_fail++;
            $display("FAIL async_pre_halt: count=%0d done=%b, required 1 1", count, done);
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({count, tc, carry, done} !== 7'b0) begin
            n_fail++;
            $display("FAIL async_reset_done: count=%0d tc=%b carry=%b done=%b, required all 0", count, tc, carry, done);
        end
        @(negedge clk);
        rst_n = 1'b1;
        mode = 0;
    endtask

    initial begin
        test_reset;
        test_auto_reload;
        test_one_shot;
        test_load_vs_enable;
        test_wrap;
        test_degenerate;
        test_async_reset;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
